// File: rtl/frame_scheduler.sv
// frame_scheduler: round-robin packer of two payload sources into the transmitter frame buffer.
// Define FRAME_SCHED_IDLE_FILL_EN to emit idle frames after 1024 quiet IDLE cycles.
module frame_scheduler #(
    parameter int FRAME_LENGTH = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_valid,
    input  logic [15:0] s0_data,
    input  logic        s0_last,
    input  logic        s1_valid,
    input  logic [15:0] s1_data,
    input  logic        s1_last,
    output logic        s0_ready,
    output logic        s1_ready,
    output logic [7:0]  tx_write_addr,
    output logic [15:0] tx_write_data,
    output logic        tx_wren,
    output logic        tx_go,
    input  logic        tx_busy,
    input  logic        tx_frame_complete,
    output logic        sched_busy,
    output logic [15:0] frames_sent,
    output logic        tx_err
);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [7:0] LAST_ADDR = 8'(FRAME_LENGTH - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, PAYLOAD, PAD, HEADER, GO, WAIT_BUSY, WAIT_DONE
    } state_t;

    state_t        state, state_d;
    logic [3:0]    chan, chan_d;
    logic          rr_ptr, rr_ptr_d;
    logic [7:0]    addr, addr_d;
    logic [7:0]    cnt, cnt_d;
    logic [TW-1:0] to_cnt, to_cnt_d;
    logic [7:0]    wr_addr_d;
    logic [15:0]   wr_data_d;
    logic          wren_d, go_d, err_d;
    logic [15:0]   frames_d;
    logic          sel_valid, sel_last;
    logic [15:0]   sel_data;
    logic          idle_fire;

    assign sel_valid = chan[0] ? s1_valid : s0_valid;
    assign sel_last  = chan[0] ? s1_last  : s0_last;
    assign sel_data  = chan[0] ? s1_data  : s0_data;

    // Ready depends only on state and grant, never on the sources' valid.
    assign s0_ready = (state == PAYLOAD) && (chan == 4'd0);
    assign s1_ready = (state == PAYLOAD) && (chan == 4'd1);

`ifdef FRAME_SCHED_IDLE_FILL_EN
    logic [9:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (!rst)
            idle_cnt <= '0;
        else if (state == IDLE && !s0_valid && !s1_valid)
            idle_cnt <= idle_cnt + 10'd1;
        else
            idle_cnt <= '0;
    end

    assign idle_fire = (state == IDLE) && !s0_valid && !s1_valid
                     && (idle_cnt == 10'h3FF);
`else
    assign idle_fire = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        chan_d    = chan;
        rr_ptr_d  = rr_ptr;
        addr_d    = addr;
        cnt_d     = cnt;
        to_cnt_d  = to_cnt;
        wren_d    = 1'b0;
        go_d      = 1'b0;
        wr_addr_d = tx_write_addr;
        wr_data_d = tx_write_data;
        frames_d  = frames_sent;
        err_d     = tx_err;
        unique case (state)
            IDLE: begin
                addr_d = 8'd1;
                cnt_d  = 8'd0;
                if (s0_valid || s1_valid) begin
                    state_d = PAYLOAD;
                    if (s0_valid && s1_valid)
                        chan_d = {3'd0, rr_ptr};
                    else
                        chan_d = {3'd0, s1_valid};
                end else if (idle_fire) begin
                    // Idle frame: skip payload, pad every slot with zero.
                    state_d = PAD;
                    chan_d  = 4'hF;
                end
            end
            PAYLOAD: begin
                if (sel_valid) begin
                    wren_d    = 1'b1;
                    wr_addr_d = addr;
                    wr_data_d = sel_data;
                    addr_d    = addr + 8'd1;
                    cnt_d     = cnt + 8'd1;
                    if (sel_last || (cnt + 8'd1) == LAST_ADDR) begin
                        if ((addr + 8'd1) <= LAST_ADDR)
                            state_d = PAD;
                        else
                            state_d = HEADER;
                    end
                end
            end
            PAD: begin
                wren_d    = 1'b1;
                wr_addr_d = addr;
                wr_data_d = 16'h0000;
                if (addr == LAST_ADDR)
                    state_d = HEADER;
                else
                    addr_d = addr + 8'd1;
            end
            HEADER: begin
                wren_d    = 1'b1;
                wr_addr_d = 8'd0;
                wr_data_d = {4'hA, chan, cnt};
                state_d   = GO;
            end
            GO: begin
                go_d     = 1'b1;
                to_cnt_d = '0;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (to_cnt == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (tx_frame_complete) begin
                    frames_d = frames_sent + 16'd1;
                    if (chan != 4'hF)
                        rr_ptr_d = ~chan[0];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            chan          <= 4'd0;
            rr_ptr        <= 1'b0;
            addr          <= 8'd0;
            cnt           <= 8'd0;
            to_cnt        <= '0;
            tx_wren       <= 1'b0;
            tx_write_addr <= 8'd0;
            tx_write_data <= 16'd0;
            tx_go         <= 1'b0;
            sched_busy    <= 1'b0;
            frames_sent   <= 16'd0;
            tx_err        <= 1'b0;
        end else begin
            state         <= state_d;
            chan          <= chan_d;
            rr_ptr        <= rr_ptr_d;
            addr          <= addr_d;
            cnt           <= cnt_d;
            to_cnt        <= to_cnt_d;
            tx_wren       <= wren_d;
            tx_write_addr <= wr_addr_d;
            tx_write_data <= wr_data_d;
            tx_go         <= go_d;
            sched_busy    <= (state_d != IDLE);
            frames_sent   <= frames_d;
            tx_err        <= err_d;
        end
    end
endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: directed and randomized checks of frame_scheduler
// against a frame-level reference model of buffer writes.
module tb_frame_scheduler;
    localparam int FL = 4;
    localparam int TO = 8;

    typedef struct packed {
        logic        go;
        logic [7:0]  a;
        logic [15:0] d;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_valid, s0_last, s1_valid, s1_last;
    logic [15:0] s0_data, s1_data;
    logic        s0_ready, s1_ready;
    logic [7:0]  tx_write_addr;
    logic [15:0] tx_write_data;
    logic        tx_wren, tx_go, tx_busy, tx_frame_complete;
    logic        sched_busy, tx_err;
    logic [15:0] frames_sent;

    always #5 clk = ~clk;

    frame_scheduler #(.FRAME_LENGTH(FL), .BUSY_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last),
        .s0_ready(s0_ready), .s1_ready(s1_ready),
        .tx_write_addr(tx_write_addr), .tx_write_data(tx_write_data),
        .tx_wren(tx_wren), .tx_go(tx_go),
        .tx_busy(tx_busy), .tx_frame_complete(tx_frame_complete),
        .sched_busy(sched_busy), .frames_sent(frames_sent), .tx_err(tx_err)
    );

    logic [16:0] q0[$], q1[$];
    int  p0 = 0, p1 = 0;
    ev_t ev_log[$], exp_q[$];
    int  cyc = 0, go_cyc = 0, rdy_cyc = 0;
    bit  rdy_prev = 0;
    bit  stall_en = 0, resp_en = 1, inj_tog = 0;
    int  checks = 0, passed = 0, fails = 0;
    bit  mrr = 0;
    int  mframes = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (tx_wren) ev_log.push_back('{1'b0, tx_write_addr, tx_write_data});
            if (tx_go) begin
                ev_log.push_back('{1'b1, 8'h00, 16'h0000});
                go_cyc = cyc;
            end
            if ((s0_ready || s1_ready) && !rdy_prev) rdy_cyc = cyc;
            rdy_prev = s0_ready || s1_ready;
        end
    end

    initial begin : drv0
        bit acc;
        s0_valid = 0; s0_data = 0; s0_last = 0;
        forever begin
            @(negedge clk);
            acc = s0_valid && s0_ready;
            @(posedge clk); #1;
            if (acc) p0++;
            if (p0 < q0.size() && !(stall_en && s0_ready && $urandom_range(0, 2) == 0)) begin
                s0_valid = 1;
                {s0_last, s0_data} = q0[p0];
            end else s0_valid = 0;
        end
    end

    initial begin : drv1
        bit acc;
        s1_valid = 0; s1_data = 0; s1_last = 0;
        forever begin
            @(negedge clk);
            acc = s1_valid && s1_ready;
            @(posedge clk); #1;
            if (acc) p1++;
            if (p1 < q1.size() && !(stall_en && s1_ready && $urandom_range(0, 2) == 0)) begin
                s1_valid = 1;
                {s1_last, s1_data} = q1[p1];
            end else s1_valid = 0;
        end
    end

    initial begin : txm
        bit seen;
        seen = 0;
        tx_busy = 0; tx_frame_complete = 0;
        forever begin
            @(negedge clk);
            if (tx_go && resp_en) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                @(posedge clk); #1 tx_busy = 1;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 tx_frame_complete = 1;
                @(posedge clk); #1;
                tx_frame_complete = 0;
                tx_busy = 0;
            end else if (inj_tog != seen) begin
                seen = inj_tog;
                @(posedge clk); #1 tx_frame_complete = 1;
                @(posedge clk); #1 tx_frame_complete = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ev_d(input int i);
        return (i < ev_log.size()) ? 32'(ev_log[i].d) : 32'hFFFF_FFFF;
    endfunction

    // Frame-level model: slice pending packets into frames by round robin.
    task automatic model_run();
        logic [16:0] m0[$], m1[$];
        logic [15:0] w[$];
        logic [16:0] x;
        bit ch;
        int n;
        for (int i = p0; i < q0.size(); i++) m0.push_back(q0[i]);
        for (int i = p1; i < q1.size(); i++) m1.push_back(q1[i]);
        while (m0.size() > 0 || m1.size() > 0) begin
            ch = (m0.size() > 0 && m1.size() > 0) ? mrr : (m0.size() == 0);
            n = 0;
            w.delete();
            forever begin
                x = ch ? m1.pop_front() : m0.pop_front();
                w.push_back(x[15:0]);
                n++;
                if (x[16] || n == FL - 1) break;
            end
            for (int a = 1; a < FL; a++)
                exp_q.push_back('{1'b0, 8'(a), (a <= n) ? w[a-1] : 16'h0000});
            exp_q.push_back('{1'b0, 8'h00, {4'hA, 3'b000, ch, 8'(n)}});
            exp_q.push_back('{1'b1, 8'h00, 16'h0000});
            mrr = !ch;
            mframes++;
        end
    endtask

    task automatic run_frames(input string tag, input int budget, input bit timing);
        bit done;
        ev_log.delete();
        exp_q.delete();
        model_run();
        done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            done = (frames_sent == 16'(mframes)) && !sched_busy
                 && p0 == q0.size() && p1 == q1.size();
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_frames"}, 32'(frames_sent), 32'(16'(mframes)));
        check({tag, "_nev"}, 32'(ev_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < ev_log.size(); i++)
            check($sformatf("%s_ev%0d", tag, i), {7'd0, ev_log[i]}, {7'd0, exp_q[i]});
        if (timing) check({tag, "_go_lat"}, 32'(go_cyc - rdy_cyc), 32'd5);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        mrr = 0;
        mframes = 0;
    endtask

    task automatic push_pkt(input bit src, input int len, input logic [15:0] base);
        for (int i = 0; i < len; i++) begin
            if (src) q1.push_back({i == len - 1, base + 16'(i)});
            else     q0.push_back({i == len - 1, base + 16'(i)});
        end
    endtask

    initial begin : main
        bit done, seen_act;
        logic [15:0] fr;
        rst = 0;
        repeat (3) @(negedge clk);
        check("rst_wren", 32'(tx_wren), 0);
        check("rst_go", 32'(tx_go), 0);
        check("rst_addr", 32'(tx_write_addr), 0);
        check("rst_data", 32'(tx_write_data), 0);
        check("rst_busy", 32'(sched_busy), 0);
        check("rst_frames", 32'(frames_sent), 0);
        check("rst_err", 32'(tx_err), 0);
        check("rst_rdy0", 32'(s0_ready), 0);
        check("rst_rdy1", 32'(s1_ready), 0);
        rst = 1;

        @(negedge clk);
        q0.push_back({1'b0, 16'h0001});
        q0.push_back({1'b1, 16'habcd});
        run_frames("t1", 200, 1);
        check("t1_hdr", ev_d(3), 32'h0000_A002);

        do_reset();
        push_pkt(0, 3, 16'h1000);
        push_pkt(1, 3, 16'h2000);
        run_frames("t2", 300, 1);
        check("t2_hdr0", ev_d(3), 32'h0000_A003);
        check("t2_hdr1", ev_d(8), 32'h0000_A103);

        @(negedge clk);
        push_pkt(1, 5, 16'h3001);
        run_frames("t3", 300, 1);
        check("t3_hdr0", ev_d(3), 32'h0000_A103);
        check("t3_hdr1", ev_d(8), 32'h0000_A102);

        stall_en = 1;
        for (int it = 0; it < 6; it++) begin
            @(negedge clk);
            repeat ($urandom_range(0, 2))
                push_pkt(0, $urandom_range(1, 6), 16'($urandom));
            repeat ($urandom_range(0, 2))
                push_pkt(1, $urandom_range(1, 6), 16'($urandom));
            run_frames($sformatf("rnd%0d", it), 3000, 0);
        end
        stall_en = 0;

        seen_act = 0;
        repeat (1100) begin
            @(negedge clk);
            seen_act |= sched_busy | tx_wren | tx_go;
        end
        check("idle_quiet", 32'(seen_act), 0);

        resp_en = 0;
        @(negedge clk);
        q0.push_back({1'b1, 16'h0055});
        done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            done = tx_go;
        end
        check("to_go_seen", 32'(done), 32'd1);
        fr = frames_sent;
        repeat (7) @(negedge clk);
        check("to_err_early", 32'(tx_err), 0);
        @(negedge clk);
        check("to_err_set", 32'(tx_err), 32'd1);
        check("to_idle", 32'(sched_busy), 0);
        check("to_frames", 32'(frames_sent), 32'(fr));
        inj_tog = ~inj_tog;
        repeat (6) @(negedge clk);
        check("to_stray_done", 32'(frames_sent), 32'(fr));
        check("to_err_sticky", 32'(tx_err), 32'd1);
        do_reset();
        check("to_err_clr", 32'(tx_err), 0);
        check("to_frames_clr", 32'(frames_sent), 0);
        resp_en = 1;

        @(negedge clk);
        push_pkt(0, 3, 16'h0111);
        done = 0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            done = s0_ready;
        end
        check("rp_ready", 32'(done), 32'd1);
        @(negedge clk);
        check("rp_pre_wren", 32'(tx_wren), 32'd1);
        rst = 0;
        @(negedge clk);
        check("rp_wren", 32'(tx_wren), 0);
        check("rp_addr", 32'(tx_write_addr), 0);
        check("rp_data", 32'(tx_write_data), 0);
        check("rp_rdy0", 32'(s0_ready), 0);
        check("rp_busy", 32'(sched_busy), 0);
        check("rp_go", 32'(tx_go), 0);
        rst = 1;
        mrr = 0;
        mframes = 0;
        run_frames("rp", 300, 1);
        check("rp_first_addr", ev_log.size() > 0 ? 32'(ev_log[0].a) : 32'hFFFF, 32'd1);
        check("rp_hdr", ev_d(3), 32'h0000_A001);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Sequences `frame_transmitter` by sharing its frame buffer write port between two payload sources. Grants one source per frame using round-robin arbitration, streams its words into buffer addresses 1..FRAME_LENGTH-1, zero-pads, writes a header at address 0, pulses `go` and waits for `frame_complete`. Sits in the `clk` domain between the payload producers and the transmitter.

## Interface
- FRAME_LENGTH, 4, buffer words per frame including header (2..255); must match transmitter `frame_length`
- BUSY_TIMEOUT, 8, cycles allowed after `tx_go` for `tx_busy` to rise
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- s0_valid, s1_valid  in  1  source word valid
- s0_data, s1_data  in  16  source word
- s0_last, s1_last  in  1  last word of source packet
- s0_ready, s1_ready  out  1  word accepted when valid & ready
- tx_write_addr  out  8  buffer address
- tx_write_data  out  16  buffer data
- tx_wren  out  1  buffer write strobe
- tx_go  out  1  one-cycle frame start
- tx_busy  in  1  transmitter busy (synchronous to `clk`)
- tx_frame_complete  in  1  one-cycle end-of-frame pulse (synchronous to `clk`)
- sched_busy  out  1  high in every state except IDLE
- frames_sent  out  16  completed frames, wraps 0xFFFF→0
- tx_err  out  1  sticky busy-timeout flag

## Operation
- States: IDLE, PAYLOAD, PAD, HEADER, GO, WAIT_BUSY, WAIT_DONE.
- IDLE: if any `sN_valid`, grant: both valid → channel `rr_ptr`; else the valid one. Next state PAYLOAD; payload address ← 1, count ← 0.
- PAYLOAD: granted `sN_ready`=1. Each accepted word → `tx_wren`=1, addr=payload address, data=`sN_data`; address/count +1. Exit when `sN_last` accepted or count reaches FRAME_LENGTH-1 (truncation: later words belong to the next frame). Exit to PAD if address < FRAME_LENGTH, else HEADER.
- PAD: write 0x0000 at each remaining address up to FRAME_LENGTH-1, one per cycle, then HEADER.
- HEADER: write addr 0, data = {4'hA, 4-bit channel id, 8-bit count}. Next GO.
- GO: `tx_go`=1 for one cycle; start timeout counter; next WAIT_BUSY.
- WAIT_BUSY: `tx_busy`=1 → WAIT_DONE; BUSY_TIMEOUT cycles without it → set `tx_err`, go IDLE (frame dropped, not counted).
- WAIT_DONE: on `tx_frame_complete` → `frames_sent`+1, `rr_ptr` ← other channel than the one just served, IDLE.
- `tx_frame_complete` outside WAIT_DONE ignored. `tx_err` cleared only by reset.
- Non-granted `sN_ready` always 0; `sN_ready` is a function of state/grant only, never of `sN_valid`.

## Timing
- Reset (`rst`=0 at a `clk` edge), also mid-frame: state IDLE, all outputs 0, `frames_sent`=0, `tx_err`=0, `rr_ptr`=0, `tx_write_addr`=0, `tx_write_data`=0. Partial buffer contents not cleaned up.
- All outputs registered; `tx_wren`/addr/data change together.
- Grant: first `sN_ready` in the cycle after IDLE sees valid.
- One word per cycle max; source stall (valid low) holds state, `tx_wren`=0.
- Minimum frame with FRAME_LENGTH=4, source sends 3 back-to-back words: 1 grant + 3 payload + 1 header + 1 go cycle; `tx_go` 5 cycles after grant cycle.
- Header write always the last buffer write before `tx_go`; `tx_go` follows it in the next cycle.
- Back-to-back frames: IDLE re-arbitrates the cycle after WAIT_DONE exit.

## Configuration
- `FRAME_SCHED_IDLE_FILL_EN`: when defined, if IDLE persists for 1024 consecutive cycles with no `sN_valid`, scheduler sends an idle frame: all payload addresses 0x0000, header {4'hA, 4'hF, 8'h00}, then GO/WAIT as normal, counted in `frames_sent`, `rr_ptr` unchanged. Counter resets on any grant. Without the macro, IDLE waits indefinitely and no idle frames are produced.

## Test plan
- FRAME_LENGTH=4, s0 sends 0x0001 then 0xabcd with last → writes (1,0x0001),(2,0xabcd),(3,0x0000),(0,0xA002), one `tx_go`; after `tx_busy`+`tx_frame_complete`, `frames_sent`=1.
- s0 and s1 valid simultaneously from reset, each 3 words → s0 frame first (header 0xA003), then s1 (header 0xA103); `frames_sent`=2.
- s1 sends 5 words without last, FRAME_LENGTH=4 → frame 1 holds words 1-3 (header 0xA103), frame 2 holds words 4-5 padded (header 0xA102).
- `tx_busy` held 0 after `tx_go` → after 8 cycles `tx_err`=1, state IDLE, `frames_sent` unchanged; stays 1 until reset.
- `rst`=0 during PAYLOAD → next cycle all outputs 0, `s0_ready`=0; new frame after release starts at addr 1.
- With `FRAME_SCHED_IDLE_FILL_EN`, no valid for 1024 cycles → idle frame, header 0xAF00, three 0x0000 payload writes.
